// File: rtl/simt_alu_pipe_pkg.sv
// Shared opcode map, ALU operation enum and decode helper for the SIMT integer ALU.
package simt_alu_pipe_pkg;

  localparam logic [7:0] OP_ADDI  = 8'd14;
  localparam logic [7:0] OP_SLTI  = 8'd15;
  localparam logic [7:0] OP_SLTIU = 8'd16;
  localparam logic [7:0] OP_XORI  = 8'd17;
  localparam logic [7:0] OP_ORI   = 8'd18;
  localparam logic [7:0] OP_ANDI  = 8'd19;
  localparam logic [7:0] OP_SLLI  = 8'd20;
  localparam logic [7:0] OP_SRLI  = 8'd21;
  localparam logic [7:0] OP_SRAI  = 8'd22;
  localparam logic [7:0] OP_ADD   = 8'd23;
  localparam logic [7:0] OP_SUB   = 8'd24;
  localparam logic [7:0] OP_SLL   = 8'd25;
  localparam logic [7:0] OP_SLT   = 8'd26;
  localparam logic [7:0] OP_SLTU  = 8'd27;
  localparam logic [7:0] OP_XOR   = 8'd28;
  localparam logic [7:0] OP_SRL   = 8'd29;
  localparam logic [7:0] OP_SRA   = 8'd30;
  localparam logic [7:0] OP_OR    = 8'd31;
  localparam logic [7:0] OP_AND   = 8'd32;

  localparam logic [31:0] ALU_ILLEGAL_VAL = 32'hE2202;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_t;

  typedef struct packed {
    alu_op_t op;
    logic    use_imm;
    logic    illegal;
  } dec_t;

  function automatic dec_t decode_op(input logic [7:0] opcode);
    dec_t d;
    d.op      = AluAdd;
    d.use_imm = (opcode >= OP_ADDI) && (opcode <= OP_SRAI);
    d.illegal = 1'b0;
    case (opcode)
      OP_ADDI, OP_ADD:  d.op = AluAdd;
      OP_SUB:           d.op = AluSub;
      OP_SLLI, OP_SLL:  d.op = AluSll;
      OP_SLTI, OP_SLT:  d.op = AluSlt;
      OP_SLTIU, OP_SLTU: d.op = AluSltu;
      OP_XORI, OP_XOR:  d.op = AluXor;
      OP_SRLI, OP_SRL:  d.op = AluSrl;
      OP_SRAI, OP_SRA:  d.op = AluSra;
      OP_ORI, OP_OR:    d.op = AluOr;
      OP_ANDI, OP_AND:  d.op = AluAnd;
      default:          d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_lane.sv
// Combinational single-lane integer ALU; one instance per SIMT thread.
module alu_lane
  import simt_alu_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_t         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned ShW = $clog2(XLEN);

  logic [ShW-1:0] shamt;
  assign shamt = b_i[ShW-1:0];

  always_comb begin
    result_o = '0;
    unique case (op_i)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i + ~b_i + XLEN'(1);
      AluSll:  result_o = a_i << shamt;
      AluSlt:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      AluSltu: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      AluXor:  result_o = a_i ^ b_i;
      AluSrl:  result_o = a_i >> shamt;
      AluSra:  result_o = $signed(a_i) >>> shamt;
      AluOr:   result_o = a_i | b_i;
      AluAnd:  result_o = a_i & b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/simt_alu_pipe.sv
// Two-stage, multi-lane SIMT integer ALU with valid/ready handshake on both sides.
module simt_alu_pipe
  import simt_alu_pipe_pkg::*;
#(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_W     = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_opcode,
  input  logic [NUM_LANES-1:0]      in_mask,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic [NUM_LANES*XLEN-1:0] in_rs1,
  input  logic [NUM_LANES*XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0]           in_imm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_LANES-1:0]      out_mask,
  output logic [TAG_W-1:0]          out_tag,
  output logic [NUM_LANES*XLEN-1:0] out_result,
  output logic                      out_illegal
);

  localparam logic [XLEN-1:0] IllegalVal = XLEN'(ALU_ILLEGAL_VAL);

  dec_t dec;
  assign dec = decode_op(in_opcode);

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic accept, s2_ready, s1_move;

  alu_op_t                s1_op_q;
  logic                   s1_use_imm_q, s1_illegal_q;
  logic [NUM_LANES-1:0]   s1_mask_q;
  logic [TAG_W-1:0]       s1_tag_q;
  logic [XLEN-1:0]        s1_imm_q;

  logic                   s2_illegal_q;
  logic [NUM_LANES-1:0]   s2_mask_q;
  logic [TAG_W-1:0]       s2_tag_q;

  // S2 can take a beat if empty or its current beat leaves this cycle.
  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_move  = s1_valid_q && s2_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (accept)       s1_valid_d = 1'b1;
    else if (s1_move) s1_valid_d = 1'b0;
    if (s1_move)        s2_valid_d = 1'b1;
    else if (out_ready) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s1_op_q      <= AluAdd;
      s1_use_imm_q <= 1'b0;
      s1_illegal_q <= 1'b0;
      s1_mask_q    <= '0;
      s1_tag_q     <= '0;
      s1_imm_q     <= '0;
      s2_illegal_q <= 1'b0;
      s2_mask_q    <= '0;
      s2_tag_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_op_q      <= dec.op;
        s1_use_imm_q <= dec.use_imm;
        s1_illegal_q <= dec.illegal;
        s1_mask_q    <= in_mask;
        s1_tag_q     <= in_tag;
        s1_imm_q     <= in_imm;
      end
      if (s1_move) begin
        s2_illegal_q <= s1_illegal_q;
        s2_mask_q    <= s1_mask_q;
        s2_tag_q     <= s1_tag_q;
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [XLEN-1:0] rs1_q, rs2_q, res_q, op_b, lane_res;

    // Operand and result registers of idle lanes stay frozen to save toggling.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rs1_q <= '0;
        rs2_q <= '0;
        res_q <= '0;
      end else begin
        if (accept && in_mask[l]) begin
          rs1_q <= in_rs1[l*XLEN +: XLEN];
          rs2_q <= in_rs2[l*XLEN +: XLEN];
        end
        if (s1_move && s1_mask_q[l]) begin
          res_q <= s1_illegal_q ? IllegalVal : lane_res;
        end
      end
    end

    assign op_b = s1_use_imm_q ? s1_imm_q : rs2_q;

    alu_lane #(
      .XLEN(XLEN)
    ) u_alu_lane (
      .op_i    (s1_op_q),
      .a_i     (rs1_q),
      .b_i     (op_b),
      .result_o(lane_res)
    );

    assign out_result[l*XLEN +: XLEN] = s2_mask_q[l] ? res_q : '0;
  end

  assign out_valid   = s2_valid_q;
  assign out_mask    = s2_mask_q;
  assign out_tag     = s2_tag_q;
  assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_simt_alu_pipe.sv
// Directed-vector bench for simt_alu_pipe with a spec-level lane model and an output scoreboard.
module tb_simt_alu_pipe;
  localparam int NL = 8;
  localparam int XL = 32;
  localparam int TW = 6;

  logic              clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [7:0]        in_opcode;
  logic [NL-1:0]     in_mask, out_mask;
  logic [TW-1:0]     in_tag, out_tag;
  logic [NL*XL-1:0]  in_rs1, in_rs2, out_result;
  logic [XL-1:0]     in_imm;

  simt_alu_pipe #(
    .NUM_LANES(NL),
    .XLEN     (XL),
    .TAG_W    (TW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_mask    (in_mask),
    .in_tag     (in_tag),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mask   (out_mask),
    .out_tag    (out_tag),
    .out_result (out_result),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]        opc;
    logic [7:0]        mask;
    logic [5:0]        tag;
    logic [7:0][31:0]  rs1;
    logic [7:0][31:0]  rs2;
    logic [31:0]       imm;
    logic              pin_v;
    logic [31:0]       pin;
  } vec_t;

  typedef struct packed {
    logic [7:0]        mask;
    logic [5:0]        tag;
    logic              ill;
    logic [7:0][31:0]  res;
    logic              pin_v;
    logic [31:0]       pin;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-lane result straight from the opcode table: imm forms 14-22, reg forms 23-32.
  function automatic logic [31:0] model_lane(input int opc, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] imm);
    logic [31:0] s;
    s = (opc <= 22) ? imm : b;
    case (opc)
      14, 23:  return a + s;
      24:      return a - s;
      15, 26:  return ($signed(a) < $signed(s)) ? 32'd1 : 32'd0;
      16, 27:  return (a < s) ? 32'd1 : 32'd0;
      17, 28:  return a ^ s;
      18, 31:  return a | s;
      19, 32:  return a & s;
      20, 25:  return a << s[4:0];
      21, 29:  return a >> s[4:0];
      22, 30:  return $signed(a) >>> s[4:0];
      default: return 32'hE2202;
    endcase
  endfunction

  function automatic exp_t model_beat(input vec_t v);
    exp_t e;
    e.mask  = v.mask;
    e.tag   = v.tag;
    e.ill   = (v.opc < 8'd14) || (v.opc > 8'd32);
    e.pin_v = v.pin_v;
    e.pin   = v.pin;
    for (int l = 0; l < NL; l++)
      e.res[l] = v.mask[l] ? model_lane(int'(v.opc), v.rs1[l], v.rs2[l], v.imm) : 32'd0;
    return e;
  endfunction

  function automatic vec_t mk(input int opc, input logic [7:0] m, input logic [5:0] t,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic pv, input logic [31:0] pin);
    vec_t v;
    v.opc = 8'(opc); v.mask = m; v.tag = t; v.imm = imm; v.pin_v = pv; v.pin = pin;
    for (int l = 0; l < NL; l++) begin
      v.rs1[l] = a;
      v.rs2[l] = b;
    end
    return v;
  endfunction

  // Drive at negedge, decide acceptance just before the rising edge.
  task automatic send(input vec_t v, output int stalls);
    stalls = 0;
    @(negedge clk);
    in_opcode = v.opc; in_mask = v.mask; in_tag = v.tag;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm; in_valid = 1'b1;
    forever begin
      #4;
      if (in_ready) begin
        exp_q.push_back(model_beat(v));
        @(posedge clk);
        break;
      end
      stalls++;
      if (stalls > 50) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: in_ready stuck low for %0d cycles", stalls);
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    #4;
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: compares every cycle out_valid is high; pops on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: got tag %h, expected no output", out_tag);
        end else begin
          e = exp_q[0];
          check("out_mask", 32'(out_mask), 32'(e.mask));
          check("out_tag", 32'(out_tag), 32'(e.tag));
          check("out_illegal", 32'(out_illegal), 32'(e.ill));
          for (int l = 0; l < NL; l++)
            check($sformatf("lane%0d_result tag%h", l, e.tag), out_result[l*32 +: 32], e.res[l]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (e.pin_v)
              for (int l = 0; l < NL; l++)
                if (e.mask[l])
                  check($sformatf("pin_lane%0d tag%h", l, e.tag), out_result[l*32 +: 32], e.pin);
          end
        end
      end
    end
  end

  vec_t vtab[$];
  int   st;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_opcode = '0; in_mask = '0;
    in_tag = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_mask", 32'(out_mask), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_result_lo", out_result[31:0], 32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back SUB stream must never stall.
    for (int i = 0; i < 4; i++) begin
      send(mk(24, 8'hFF, 6'(i + 1), 32'd5, 32'd7, 32'd0, 1'b1, 32'hFFFF_FFFE), st);
      check("stream_no_stall", 32'(st), 32'd0);
    end

    vtab.push_back(mk(22, 8'hA5, 6'h2A, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 32'hF800_0000));
    vtab.push_back(mk(26, 8'hFF, 6'h05, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 32'd1));
    vtab.push_back(mk(27, 8'hFF, 6'h06, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 32'd0));
    vtab.push_back(mk(25, 8'hFF, 6'h07, 32'd3, 32'd33, 32'd0, 1'b1, 32'd6));
    vtab.push_back(mk(40, 8'h3C, 6'h08, 32'd9, 32'd9, 32'd9, 1'b1, 32'h000E_2202));
    vtab.push_back(mk(14, 8'hFF, 6'h09, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 32'd0));
    vtab.push_back(mk(23, 8'h0F, 6'h0A, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1, 32'h8000_0000));
    vtab.push_back(mk(28, 8'hF0, 6'h0B, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b1, 32'h0FF0_0FF0));
    vtab.push_back(mk(29, 8'hFF, 6'h0C, 32'h8000_0000, 32'd31, 32'd0, 1'b1, 32'd1));
    vtab.push_back(mk(30, 8'hFF, 6'h0D, 32'h8000_0000, 32'd4, 32'd0, 1'b1, 32'hF800_0000));
    vtab.push_back(mk(31, 8'h81, 6'h0E, 32'h0F00, 32'h00F0, 32'd0, 1'b1, 32'h0FF0));
    vtab.push_back(mk(32, 8'hFF, 6'h0F, 32'hF0F0, 32'hFF00, 32'd0, 1'b1, 32'hF000));
    vtab.push_back(mk(15, 8'hFF, 6'h10, 32'hFFFF_FFFE, 32'd0, 32'd3, 1'b1, 32'd1));
    vtab.push_back(mk(16, 8'hFF, 6'h11, 32'hFFFF_FFFE, 32'd0, 32'd3, 1'b1, 32'd0));
    vtab.push_back(mk(17, 8'hFF, 6'h12, 32'h00FF, 32'd0, 32'h0F, 1'b1, 32'h00F0));
    vtab.push_back(mk(18, 8'hFF, 6'h13, 32'h0100, 32'd0, 32'd1, 1'b1, 32'h0101));
    vtab.push_back(mk(19, 8'hFF, 6'h14, 32'h00FF, 32'd0, 32'h3C, 1'b1, 32'h003C));
    vtab.push_back(mk(20, 8'hFF, 6'h15, 32'd1, 32'd0, 32'd31, 1'b1, 32'h8000_0000));
    vtab.push_back(mk(21, 8'hFF, 6'h16, 32'h8000_0000, 32'd0, 32'd32, 1'b1, 32'h8000_0000));
    vtab.push_back(mk(13, 8'h00, 6'h17, 32'd1, 32'd2, 32'd3, 1'b0, 32'd0));
    vtab.push_back(mk(0, 8'hFF, 6'h18, 32'd1, 32'd2, 32'd3, 1'b1, 32'h000E_2202));
    vtab.push_back(mk(23, 8'h00, 6'h19, 32'd1, 32'd2, 32'd0, 1'b0, 32'd0));
    foreach (vtab[i]) send(vtab[i], st);

    // Lane-distinct operands across every legal opcode.
    for (int i = 0; i < 19; i++) begin
      vec_t v;
      v = mk(14 + i, 8'hFF ^ 8'(i * 37), 6'(32 + i), 32'd0, 32'd0, 32'(i * 3 + 1), 1'b0, 32'd0);
      for (int l = 0; l < NL; l++) begin
        v.rs1[l] = 32'h1357_9BDF * 32'(l + 1) + 32'(i);
        v.rs2[l] = 32'h8642_0ECA ^ 32'(l * 7 + i);
      end
      send(v, st);
    end
    wait_drain();

    // Backpressure: 4 beats while the consumer stalls.
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(mk(23, 8'hFF, 6'(48 + i), 32'(100 * i), 32'd1, 32'd0, 1'b1, 32'(100 * i + 1)), st);
      end
      begin
        repeat (3) @(negedge clk);
        #2;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid_held", 32'(out_valid), 32'd1);
        @(negedge clk);
        #2;
        check("bp_in_ready_still_low", 32'(in_ready), 32'd0);
        check("bp_out_tag_stable", 32'(out_tag), 32'h30);
        @(negedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with two beats in flight discards both.
    out_ready = 1'b0;
    send(mk(24, 8'hFF, 6'h3A, 32'd1, 32'd1, 32'd0, 1'b0, 32'd0), st);
    send(mk(24, 8'hFF, 6'h3B, 32'd1, 32'd1, 32'd0, 1'b0, 32'd0), st);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      check("post_rst_no_output", 32'(out_valid), 32'd0);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
